// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end: FSM states,
// command opcodes and default frame/data widths.
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if_piso.sv
// Parallel-load, MSB-first shifter driving miso; sout is registered so the
// first bit appears the cycle after load, and done blocks any reload.
module spi_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  sr;
    logic [CW-1:0] left;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            left <= '0;
        end else if (load && !busy && !done) begin
            sout <= din[W-1];
            sr   <= {din[W-2:0], 1'b0};
            left <= CW'(W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (left != '0) begin
                sout <= sr[W-1];
                sr   <= {sr[W-2:0], 1'b0};
                left <= left - 1'b1;
            end else begin
                // last bit has been on the line for a full cycle
                sout <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: assembles MOSI command frames into rx_data words and
// returns one byte of RAM read data on MISO after a read-data command.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_W);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-2:0] sr;
    logic               rd_addr_seen;
    logic               tx_busy;
    logic               tx_done;
    logic               tx_load;

    // read data is accepted only once the read-data frame is fully received
    assign tx_load = (state == READ_DATA) && (cnt == FULL) && !ss_n &&
                     tx_valid && !tx_busy && !tx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!ss_n) state <= CHK_CMD;
                end
                CHK_CMD: begin
                    if (ss_n) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        sr  <= {{(FRAME_W-2){1'b0}}, mosi};
                        cnt <= CNT_W'(1);
                        if (!mosi)             state <= WRITE;
                        else if (!rd_addr_seen) state <= READ_ADD;
                        else                    state <= READ_DATA;
                    end
                end
                default: begin
                    if (ss_n) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt < FULL) begin
                        sr  <= {sr[FRAME_W-3:0], mosi};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            rx_data  <= {sr, mosi};
                            rx_valid <= 1'b1;
                            if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                            if (state == READ_DATA) rd_addr_seen <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    spi_piso #(.W(DATA_W)) u_piso (
        .clk  (clk),
        .rst  (rst),
        .clr  (ss_n),
        .load (tx_load),
        .din  (tx_data),
        .sout (miso),
        .busy (tx_busy),
        .done (tx_done)
    );

endmodule
